cache_seq_ctrl: RTL and testbench
=================================

Name: cache_seq_ctrl

Overview:
Sequencing controller for the 4-way set-associative 32 KB cache datapath. It accepts one CPU request at a time (read/write) and drives the cache strobes c0..c7 in order: latch address, lookup, allocate/evict, write-back, fetch, fill and re-lookup. It also runs a req/ack handshake to main memory with a timeout. It sits between the CPU port, the cache array and the memory interface.

Parameters:
LOOKUP_WAIT, 2, cycles waited after address latch (c0) before asserting c1/c2 (cache tag compare is registered, two stages); range 1..7
MEM_TIMEOUT, 255, max cycles to wait for mem_ack per memory transaction
TMO_W, 8, width of timeout counter; MEM_TIMEOUT must be < 2**TMO_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU request present
req_write  in  1  1=write, 0=read; sampled with req_valid when req_ready=1
req_ready  out  1  controller idle, request accepted this cycle if req_valid=1
resp_valid  out  1  one-cycle completion pulse
resp_hit  out  1  first lookup hit; valid with resp_valid
resp_err  out  1  timeout or miss on re-lookup; valid with resp_valid
hit  in  1  cache hit flag
miss  in  1  cache miss flag
free  in  1  cache reports an unused way (after c5)
victim_dirty  in  1  LRU victim way is dirty (after c7)
c0..c7  out  1 each  cache strobes: c0 latch addr, c1 read, c2 write, c3 data/LRU update, c4 ask_for_data, c5 find free way, c6 fill, c7 select LRU victim
mem_req  out  1  memory transaction request
mem_we  out  1  1=write-back, 0=fetch; valid while mem_req=1
mem_ack  in  1  memory transaction complete

Behaviour:
- Moore FSM, one state per cycle unless waiting; all outputs decode from state only. Sync reset (rst=1 at posedge): state IDLE, counters 0, all outputs 0 except req_ready=1. Reset mid-transaction aborts it with no resp_valid; mem_req drops the cycle after the reset edge.
- IDLE: req_ready=1. If req_valid=1, capture req_write into op_w, clear retry flag, go to LATCH.
- LATCH: c0=1; load wait counter with LOOKUP_WAIT; go to WAIT.
- WAIT: decrement; at 1, go to COMPARE.
- COMPARE: c3=1 plus c1 (op_w=0) or c2 (op_w=1); go to RESOLVE.
- RESOLVE: hit=1 → RESP, with resp_hit = ~retry. Otherwise (hit=0, whatever miss is) → ERRRESP if retry=1, else ALLOC.
- ALLOC: c5=1 → ALLOC_CHK. ALLOC_CHK: free=1 → FETCH, else → EVICT.
- EVICT: c7=1 → EVICT_CHK. EVICT_CHK: victim_dirty=1 → WB, else → FETCH.
- WB: mem_req=1, mem_we=1 until mem_ack → FETCH.
- FETCH: c4=1, mem_req=1, mem_we=0 until mem_ack → FILL.
- FILL: c6=1; set retry=1 → LATCH (re-lookup, c0 again).
- Timeout: counter clears on entry to WB/FETCH and increments each cycle without mem_ack. If it reaches MEM_TIMEOUT with mem_ack=0 → ERRRESP. mem_ack in the same cycle as the limit wins. mem_ack outside WB/FETCH is ignored.
- RESP: resp_valid=1 → IDLE. ERRRESP: resp_valid=1, resp_err=1, resp_hit=0 → IDLE. resp_hit/resp_err are 0 whenever resp_valid=0.
- req_ready=0 in every state except IDLE; the next request can be accepted the cycle after resp_valid.
- Minimum hit latency, accept edge to resp_valid: LATCH+WAIT(LOOKUP_WAIT)+COMPARE+RESOLVE+RESP = LOOKUP_WAIT+4 cycles (6 with defaults).

Optional Feature:
CACHE_SEQ_CTRL_STATS_EN. When defined: adds outputs stat_hits, stat_misses, stat_wbacks, stat_timeouts, each 16 bits, saturating at 16'hFFFF and cleared by rst.
- stat_hits increments on RESP with resp_hit=1.
- stat_misses increments on entry to ALLOC.
- stat_wbacks increments on WB exit by mem_ack.
- stat_timeouts increments on timeout.
When undefined: the ports and logic are absent and all other behaviour is identical.

Test Plan:
- Read hit: rst, then req_valid=1, req_write=0, bench drives hit=1 in RESOLVE → c0 at cycle 1, c1+c3 at cycle 4, resp_valid with resp_hit=1 at cycle 6, zero mem_req.
- Write miss, free way: hit=0, free=1, mem_ack after 3 cycles → sequence c2 → c5 → c4 with mem_req=1/mem_we=0 → c6 → c0 → c2 (hit=1) → resp_valid, resp_hit=0, resp_err=0.
- Read miss, dirty victim: free=0, victim_dirty=1 → c7, then WB (mem_we=1) until ack, then FETCH (mem_we=0), then fill/re-lookup; exactly two mem_req transactions.
- Timeout: FETCH with mem_ack held 0 → after 255 cycles resp_valid=1, resp_err=1, mem_req=0 next cycle, req_ready=1.
- Re-lookup miss: hit=0 on both passes → single fill, then resp_err=1; no second ALLOC.
- Reset mid-WB: rst pulsed while mem_req=1 → next cycle all c*=0, mem_req=0, req_ready=1, no resp_valid; a new request then completes normally.

Source files
------------

// File: rtl/cache_seq_ctrl.sv
// Sequencing controller for the 4-way set-associative cache datapath: strobes c0..c7 and a memory req/ack with timeout.
// Optional counters are enabled by defining CACHE_SEQ_CTRL_STATS_EN.
module cache_seq_ctrl #(
  parameter int LOOKUP_WAIT = 2,
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_write,
  output logic req_ready,
  output logic resp_valid,
  output logic resp_hit,
  output logic resp_err,
  input  logic hit,
  input  logic miss,
  input  logic free,
  input  logic victim_dirty,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic c7,
  output logic mem_req,
  output logic mem_we,
  input  logic mem_ack
`ifdef CACHE_SEQ_CTRL_STATS_EN
  ,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
  output logic [15:0] stat_wbacks,
  output logic [15:0] stat_timeouts
`endif
);

  typedef enum logic [3:0] {
    IDLE, LATCH, WAIT, COMPARE, RESOLVE, RESP, ERRRESP,
    ALLOC, ALLOC_CHK, EVICT, EVICT_CHK, WB, FETCH, FILL
  } state_t;

  state_t           state, nxt;
  logic             op_w, retry;
  logic [2:0]       wcnt;
  logic [TMO_W-1:0] tcnt;
  logic [TMO_W:0]   tcnt_inc;
  logic             tmo, in_mem;

  // Limit is reached when this no-ack cycle would bring the count to MEM_TIMEOUT.
  assign tcnt_inc = {1'b0, tcnt} + (TMO_W+1)'(1);
  assign tmo      = (tcnt_inc == (TMO_W+1)'(MEM_TIMEOUT));
  assign in_mem   = (state == WB) || (state == FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_w  <= 1'b0;
      retry <= 1'b0;
      wcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE:  if (req_valid) begin op_w <= req_write; retry <= 1'b0; end
        LATCH: wcnt <= 3'(LOOKUP_WAIT);
        WAIT:  wcnt <= wcnt - 3'd1;
        FILL:  retry <= 1'b1;
        default: ;
      endcase
      if ((nxt == WB || nxt == FETCH) && nxt != state) tcnt <= '0;
      else if (in_mem && !mem_ack)                    tcnt <= tcnt_inc[TMO_W-1:0];
    end
  end

  always_comb begin
    nxt        = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_err   = 1'b0;
    {c0, c1, c2, c3, c4, c5, c6, c7} = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = LATCH;
      end
      LATCH: begin c0 = 1'b1; nxt = WAIT; end
      WAIT:  if (wcnt <= 3'd1) nxt = COMPARE;
      COMPARE: begin
        c3 = 1'b1;
        c1 = ~op_w;
        c2 = op_w;
        nxt = RESOLVE;
      end
      // miss is informational only; absence of hit is what drives a refill
      RESOLVE:   nxt = hit ? RESP : (retry ? ERRRESP : ALLOC);
      RESP: begin
        resp_valid = 1'b1;
        resp_hit   = ~retry;
        nxt        = IDLE;
      end
      ERRRESP: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        nxt        = IDLE;
      end
      ALLOC:     begin c5 = 1'b1; nxt = ALLOC_CHK; end
      ALLOC_CHK: nxt = free ? FETCH : EVICT;
      EVICT:     begin c7 = 1'b1; nxt = EVICT_CHK; end
      EVICT_CHK: nxt = victim_dirty ? WB : FETCH;
      WB: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack)  nxt = FETCH;
        else if (tmo) nxt = ERRRESP;
      end
      FETCH: begin
        c4      = 1'b1;
        mem_req = 1'b1;
        if (mem_ack)  nxt = FILL;
        else if (tmo) nxt = ERRRESP;
      end
      FILL:    begin c6 = 1'b1; nxt = LATCH; end
      default: nxt = IDLE;
    endcase
  end

`ifdef CACHE_SEQ_CTRL_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits     <= '0;
      stat_misses   <= '0;
      stat_wbacks   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (state == RESP && !retry)                 stat_hits     <= sat_inc(stat_hits);
      if (state == RESOLVE && !hit && !retry)      stat_misses   <= sat_inc(stat_misses);
      if (state == WB && mem_ack)                  stat_wbacks   <= sat_inc(stat_wbacks);
      if (in_mem && !mem_ack && tmo)               stat_timeouts <= sat_inc(stat_timeouts);
    end
  end
`endif

endmodule

// File: tb/tb_cache_seq_ctrl.sv
// Directed bench for cache_seq_ctrl: table of whole transactions with hand-computed latencies and strobe counts.
module tb_cache_seq_ctrl;
  logic clk = 1'b0;
  logic rst, req_valid, req_write, hit, miss, free, victim_dirty, mem_ack;
  logic req_ready, resp_valid, resp_hit, resp_err, mem_req, mem_we;
  logic c0, c1, c2, c3, c4, c5, c6, c7;
`ifdef CACHE_SEQ_CTRL_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_wbacks, stat_timeouts;
`endif

  always #5 clk = ~clk;

  cache_seq_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err),
    .hit(hit), .miss(miss), .free(free), .victim_dirty(victim_dirty),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack)
`ifdef CACHE_SEQ_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses),
    .stat_wbacks(stat_wbacks), .stat_timeouts(stat_timeouts)
`endif
  );

  typedef struct {
    string nm;
    bit    wr, hit1, hit2, fr, dirty;
    int    wb_dly, fe_dly;          // ack on the Nth cycle of the transaction; 0 = never
    bit    e_hit, e_err;
    int    e_lat, e_c0, e_c1, e_c2, e_c5, e_c6, e_c7, e_ntx, e_nwb;
  } vec_t;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [13:0] outs();
    return {req_ready, resp_valid, resp_hit, resp_err, c0, c1, c2, c3, c4, c5, c6, c7, mem_req, mem_we};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input vec_t v);
    int cyc, lat, n0, n1, n2, n5, n6, n7, ntx, nwb, tc, dly;
    bit pass2, prev_req, prev_we, got_hit, got_err, bad, done;
    cyc = 0; n0 = 0; n1 = 0; n2 = 0; n5 = 0; n6 = 0; n7 = 0; ntx = 0; nwb = 0; tc = 0;
    pass2 = 0; prev_req = 0; prev_we = 0; bad = 0; done = 0; lat = -1; got_hit = 0; got_err = 0;
    hit = v.hit1; free = v.fr; victim_dirty = v.dirty; miss = ~v.hit1; mem_ack = 0;
    chk({v.nm, " ready_before"}, int'(req_ready), 1);
    req_valid = 1; req_write = v.wr;
    tick();
    req_valid = 0; req_write = 0;
    while (!done && cyc < 2000) begin
      cyc++;
      n0 += int'(c0); n1 += int'(c1); n2 += int'(c2);
      n5 += int'(c5); n6 += int'(c6); n7 += int'(c7);
      if (c6) pass2 = 1;
      hit  = pass2 ? v.hit2 : v.hit1;
      miss = ~hit;
      if (!resp_valid && (resp_hit || resp_err)) bad = 1;
      if (req_ready) bad = 1;
      if (mem_req) begin
        if (!prev_req || prev_we != mem_we) begin
          ntx++; tc = 0;
          if (mem_we) nwb++;
        end
        tc++;
        dly = mem_we ? v.wb_dly : v.fe_dly;
        mem_ack = (dly != 0) && (tc == dly);
      end else mem_ack = 0;
      prev_req = mem_req; prev_we = mem_we;
      if (resp_valid) begin
        lat = cyc; got_hit = resp_hit; got_err = resp_err; done = 1;
        bad = bad | req_ready;
      end else tick();
    end
    mem_ack = 0;
    if (!done) chk({v.nm, " no_response"}, 0, 1);
    chk({v.nm, " latency"}, lat, v.e_lat);
    chk({v.nm, " resp_hit"}, int'(got_hit), int'(v.e_hit));
    chk({v.nm, " resp_err"}, int'(got_err), int'(v.e_err));
    chk({v.nm, " c0"}, n0, v.e_c0);
    chk({v.nm, " c1"}, n1, v.e_c1);
    chk({v.nm, " c2"}, n2, v.e_c2);
    chk({v.nm, " c5"}, n5, v.e_c5);
    chk({v.nm, " c6"}, n6, v.e_c6);
    chk({v.nm, " c7"}, n7, v.e_c7);
    chk({v.nm, " mem_tx"}, ntx, v.e_ntx);
    chk({v.nm, " wb_tx"}, nwb, v.e_nwb);
    chk({v.nm, " invariants"}, int'(bad), 0);
    tick();
    chk({v.nm, " idle_after"}, int'({req_ready, mem_req, resp_valid}), 3'b100);
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1; req_valid = 0; req_write = 0; hit = 0; miss = 0; free = 0;
    victim_dirty = 0; mem_ack = 0;
    //          nm            wr h1 h2 fr dy wb  fe   eh ee lat  c0 c1 c2 c5 c6 c7 tx wb
    tbl.push_back('{"rd_hit",   0, 1, 0, 0, 0, 0,  0,   1, 0, 6,   1, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{"wr_free",  1, 0, 1, 1, 0, 0,  3,   0, 0, 17,  2, 0, 2, 1, 1, 0, 1, 0});
    tbl.push_back('{"rd_dirty", 0, 0, 1, 0, 1, 2,  3,   0, 0, 21,  2, 2, 0, 1, 1, 1, 2, 1});
    tbl.push_back('{"wr_clean", 1, 0, 1, 0, 0, 0,  1,   0, 0, 17,  2, 0, 2, 1, 1, 1, 1, 0});
    tbl.push_back('{"relookup", 0, 0, 0, 1, 0, 0,  1,   0, 1, 15,  2, 2, 0, 1, 1, 0, 1, 0});
    tbl.push_back('{"wr_hit",   1, 1, 0, 0, 0, 0,  0,   1, 0, 6,   1, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{"fe_tmo",   0, 0, 1, 1, 0, 0,  0,   0, 1, 263, 1, 1, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{"fe_limit", 0, 0, 1, 1, 0, 0,  255, 0, 0, 269, 2, 2, 0, 1, 1, 0, 1, 0});
    tbl.push_back('{"wb_tmo",   1, 0, 1, 0, 1, 0,  0,   0, 1, 265, 1, 0, 1, 1, 0, 1, 1, 1});

    tick(); tick();
    rst = 0;
    chk("reset_outputs", int'(outs()), int'(14'b10_0000_0000_0000));

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset while a write-back is outstanding: abort silently, then a clean hit.
    begin
      int n;
      bit seen_wb, seen_resp;
      n = 0; seen_wb = 0; seen_resp = 0;
      hit = 0; miss = 1; free = 0; victim_dirty = 1; mem_ack = 0;
      req_valid = 1; req_write = 0;
      tick();
      req_valid = 0;
      while (!seen_wb && n < 50) begin
        n++;
        if (mem_req && mem_we) seen_wb = 1; else tick();
      end
      chk("rst_mid_wb_reached", int'(seen_wb), 1);
      rst = 1;
      tick();
      rst = 0;
      chk("rst_mid_wb_outputs", int'(outs()), int'(14'b10_0000_0000_0000));
      for (int k = 0; k < 4; k++) begin
        tick();
        if (resp_valid || !req_ready || mem_req) seen_resp = 1;
      end
      chk("rst_mid_wb_quiet", int'(seen_resp), 0);
    end
    run_txn(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
